// File: rtl/log_mover.sv
// Log start-coordinate generator: advances every river log by its lane speed once per frame
// divider period. Optional macro LOG_LEVEL_SPEED_EN adds a 'level' speed-up input.
module log_mover #(
  parameter int unsigned NUM_OF_LOGS   = 100,
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned LOGS_PER_LANE = 5,
  parameter int unsigned SPACING       = 160,
  parameter int unsigned WRAP_SPAN     = 800,
  parameter int unsigned LANE_Y0       = 100,
  parameter int unsigned LANE_PITCH    = 40,
  parameter int unsigned BASE_SPEED    = 1,
  parameter int unsigned FRAME_DIV     = 1,
  parameter int unsigned PARK_XY       = 2000
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        frame_tick,
  input  logic        pause,
`ifdef LOG_LEVEL_SPEED_EN
  input  logic [2:0]  level,
`endif
  output logic [10:0] ObjectStartX [NUM_OF_LOGS],
  output logic [10:0] ObjectStartY [NUM_OF_LOGS],
  output logic        busy,
  output logic        update_done,
  output logic        overrun
);

  localparam int unsigned ActiveLogs = NUM_LANES * LOGS_PER_LANE;
  localparam int unsigned IdxW       = $clog2(ActiveLogs + 1);
  localparam int unsigned LaneW      = $clog2(NUM_LANES + 1);
  localparam int unsigned JW         = $clog2(LOGS_PER_LANE + 1);
  localparam int unsigned DivW       = $clog2(FRAME_DIV + 1);

  typedef enum logic [1:0] {StIdle, StTick, StUpdate, StCommit} state_e;

  state_e            state;
  logic [IdxW-1:0]   idx;
  logic [LaneW-1:0]  lane;
  logic [JW-1:0]     j;
  logic [DivW-1:0]   div_cnt;
  logic [10:0]       work_x [ActiveLogs];
`ifdef LOG_LEVEL_SPEED_EN
  logic [2:0]        level_q;
`endif

  function automatic logic [10:0] init_x(int unsigned i);
    if (i >= ActiveLogs) return 11'(PARK_XY);
    return 11'((i % LOGS_PER_LANE) * SPACING);
  endfunction

  function automatic logic [10:0] init_y(int unsigned i);
    if (i >= ActiveLogs) return 11'(PARK_XY);
    return 11'(LANE_Y0 + (i / LOGS_PER_LANE) * LANE_PITCH);
  endfunction

  // Wrap arithmetic at 12 bits; results always land back in [0, WRAP_SPAN-1].
  logic [11:0] cur_x, spd, sum;
  logic [10:0] next_x;

  always_comb begin
    cur_x = {1'b0, work_x[idx]};
`ifdef LOG_LEVEL_SPEED_EN
    spd = 12'(BASE_SPEED) + 12'(lane) + 12'(level_q);
`else
    spd = 12'(BASE_SPEED) + 12'(lane);
`endif
    sum = cur_x + spd;
    if (!lane[0]) begin
      next_x = (sum >= 12'(WRAP_SPAN)) ? 11'(sum - 12'(WRAP_SPAN)) : 11'(sum);
    end else begin
      next_x = (cur_x < spd) ? 11'(cur_x + 12'(WRAP_SPAN) - spd) : 11'(cur_x - spd);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= StIdle;
      idx         <= '0;
      lane        <= '0;
      j           <= '0;
      div_cnt     <= '0;
      busy        <= 1'b0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
`ifdef LOG_LEVEL_SPEED_EN
      level_q     <= '0;
`endif
      for (int unsigned i = 0; i < ActiveLogs; i++) work_x[i] <= init_x(i);
      for (int unsigned i = 0; i < NUM_OF_LOGS; i++) begin
        ObjectStartX[i] <= init_x(i);
        ObjectStartY[i] <= init_y(i);
      end
    end else begin
      update_done <= 1'b0;
      if (frame_tick && !pause && state != StIdle) overrun <= 1'b1;
      case (state)
        StIdle: begin
          if (frame_tick && !pause) begin
            state <= StTick;
            busy  <= 1'b1;
          end
        end
        StTick: begin
`ifdef LOG_LEVEL_SPEED_EN
          level_q <= level;
`endif
          if (div_cnt == DivW'(FRAME_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= '0;
            lane    <= '0;
            j       <= '0;
            state   <= StUpdate;
          end else begin
            div_cnt <= div_cnt + 1'b1;
            busy    <= 1'b0;
            state   <= StIdle;
          end
        end
        StUpdate: begin
          work_x[idx] <= next_x;
          if (idx == IdxW'(ActiveLogs - 1)) begin
            state <= StCommit;
          end else begin
            idx <= idx + 1'b1;
            if (j == JW'(LOGS_PER_LANE - 1)) begin
              j    <= '0;
              lane <= lane + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        StCommit: begin
          for (int unsigned i = 0; i < ActiveLogs; i++) ObjectStartX[i] <= work_x[i];
          update_done <= 1'b1;
          busy        <= 1'b0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
